// File: rtl/wb_unit_pkg.sv
// ============================================================================
// Module  : wb_unit_pkg
// Brief   : Shared writeback types: load funct3 codes, writeback FSM states,
//           register-file write enable, latched-load record, legality helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_unit_pkg;

    typedef enum logic {
        REG_NO_WE = 1'b0,
        REG_WE    = 1'b1
    } reg_we_e;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_funct_e;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } ld_req_t;

    // Byte loads accept any offset, halves need even offsets, words offset 0.
    function automatic logic ld_legal(input logic [2:0] funct3, input logic [1:0] offset);
        logic ok;
        case (funct3)
            LB, LBU: ok = 1'b1;
            LH, LHU: ok = ~offset[0];
            LW:      ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_unit_if.sv
// ============================================================================
// Module  : wb_unit_if
// Brief   : Execute/memory-side bundle into the writeback unit and the
//           register-file write port coming out of it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_unit_if;
    import wb_unit_pkg::*;

    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        ld_issue_i;
    logic [4:0]  ld_rd_i;
    logic [2:0]  ld_funct3_i;
    logic [1:0]  ld_offset_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [4:0]  pending_rd_o;
    reg_we_e     reg_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        err_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_issue_i, ld_rd_i, ld_funct3_i, ld_offset_i,
        input  mem_rvalid_i, mem_rdata_i,
        output stall_o, pending_rd_o, reg_we_o, rd_addr_o, rd_data_o, err_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_issue_i, ld_rd_i, ld_funct3_i, ld_offset_i,
        output mem_rvalid_i, mem_rdata_i,
        input  stall_o, pending_rd_o, reg_we_o, rd_addr_o, rd_data_o, err_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_unit_load_extend.sv
// ============================================================================
// Module  : wb_unit_load_extend
// Brief   : Combinational lane select and sign/zero extension of a load word,
//           plus a flag for misaligned offsets or unknown funct3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_unit_load_extend
    import wb_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte     = word_i[{offset_i, 3'b000} +: 8];
    assign w_half     = word_i[{offset_i[1], 4'b0000} +: 16];
    assign misalign_o = ~ld_legal(funct3_i, offset_i);

    always_comb begin
        data_o = word_i;
        case (funct3_i)
            LB:      data_o = {{24{w_byte[7]}}, w_byte};
            LH:      data_o = {{16{w_half[15]}}, w_half};
            LBU:     data_o = {24'h000000, w_byte};
            LHU:     data_o = {16'h0000, w_half};
            default: data_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_unit.sv
// ============================================================================
// Module  : wb_unit
// Brief   : Register-file write producer merging single-cycle ALU results and
//           one outstanding multi-cycle load. Optional macro WB_TIMEOUT_EN
//           aborts a load after TIMEOUT cycles without mem_rvalid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic     clk,
    input  logic     reset,
    wb_unit_if.slave bus
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_WAIT = WAIT_MEM;

    logic [0:0]  state_q, state_d;
    ld_req_t     ld_q, ld_d;
    reg_we_e     reg_we_q, reg_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        stall_q, stall_d;
    logic [4:0]  pending_rd_q, pending_rd_d;
    logic        err_q, err_d;

    logic [2:0]  w_ext_funct3;
    logic [1:0]  w_ext_offset;
    logic [31:0] w_ext_data;
    logic        w_misalign;
    logic        w_tmo_hit;

    // Idle: extender checks the incoming issue. Waiting: it formats the return.
    assign w_ext_funct3 = (state_q == S_WAIT) ? ld_q.funct3 : bus.ld_funct3_i;
    assign w_ext_offset = (state_q == S_WAIT) ? ld_q.offset : bus.ld_offset_i;

    wb_unit_load_extend u_load_extend (
        .funct3_i   (w_ext_funct3),
        .offset_i   (w_ext_offset),
        .word_i     (bus.mem_rdata_i),
        .data_o     (w_ext_data),
        .misalign_o (w_misalign)
    );

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_cnt_d = (state_q == S_IDLE) ? '0 : tmo_cnt_q + CNT_W'(1);
    assign w_tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ld_d         = ld_q;
        reg_we_d     = REG_NO_WE;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        stall_d      = stall_q;
        pending_rd_d = pending_rd_q;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.alu_valid_i && (bus.alu_rd_i != 5'd0)) begin
                    reg_we_d  = REG_WE;
                    rd_addr_d = bus.alu_rd_i;
                    rd_data_d = bus.alu_data_i;
                end
                if (bus.ld_issue_i) begin
                    if (w_misalign) begin
                        err_d = 1'b1;
                    end else begin
                        ld_d.rd      = bus.ld_rd_i;
                        ld_d.funct3  = bus.ld_funct3_i;
                        ld_d.offset  = bus.ld_offset_i;
                        state_d      = S_WAIT;
                        stall_d      = 1'b1;
                        pending_rd_d = bus.ld_rd_i;
                    end
                end
            end
            S_WAIT: begin
                // A return on the last permitted cycle beats the timeout.
                if (bus.mem_rvalid_i) begin
                    if (ld_q.rd != 5'd0) begin
                        reg_we_d  = REG_WE;
                        rd_addr_d = ld_q.rd;
                        rd_data_d = w_ext_data;
                    end
                    state_d      = S_IDLE;
                    stall_d      = 1'b0;
                    pending_rd_d = 5'd0;
                end else if (w_tmo_hit) begin
                    err_d        = 1'b1;
                    state_d      = S_IDLE;
                    stall_d      = 1'b0;
                    pending_rd_d = 5'd0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                stall_d      = 1'b0;
                pending_rd_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ld_q         <= '0;
            reg_we_q     <= REG_NO_WE;
            rd_addr_q    <= 5'd0;
            rd_data_q    <= 32'd0;
            stall_q      <= 1'b0;
            pending_rd_q <= 5'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_q         <= ld_d;
            reg_we_q     <= reg_we_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            stall_q      <= stall_d;
            pending_rd_q <= pending_rd_d;
            err_q        <= err_d;
        end
    end

    assign bus.reg_we_o     = reg_we_q;
    assign bus.rd_addr_o    = rd_addr_q;
    assign bus.rd_data_o    = rd_data_q;
    assign bus.stall_o      = stall_q;
    assign bus.pending_rd_o = pending_rd_q;
    assign bus.err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_unit.sv
// ============================================================================
// Module  : tb_wb_unit
// Brief   : Self-checking bench for wb_unit: random ALU writes and loads
//           against a behavioural extension/legality model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_unit;
    import wb_unit_pkg::*;

    localparam int TMO = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    wb_unit_if bus ();

    wb_unit #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_legal(input int f3, input int off);
        case (f3)
            0, 4:    return 1'b1;
            1, 5:    return (off % 2) == 0;
            2:       return off == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_ext(input int f3, input int off, input logic [31:0] w);
        longint b;
        longint h;
        b = longint'((w >> (8 * off)) & 32'hFF);
        h = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (f3)
            0:       return 32'(b >= 128 ? b - 256 : b);
            1:       return 32'(h >= 32768 ? h - 65536 : h);
            4:       return 32'(b);
            5:       return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid_i  = 1'b0;
        bus.alu_rd_i     = 5'd0;
        bus.alu_data_i   = 32'd0;
        bus.ld_issue_i   = 1'b0;
        bus.ld_rd_i      = 5'd0;
        bus.ld_funct3_i  = 3'd0;
        bus.ld_offset_i  = 2'd0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total += 6;
        if (bus.reg_we_o !== REG_NO_WE) begin bad++; $display("FAIL reset_we got=%0d want=0", bus.reg_we_o); end
        if (bus.rd_addr_o !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", bus.rd_addr_o); end
        if (bus.rd_data_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.rd_data_o); end
        if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall_o); end
        if (bus.pending_rd_o !== 5'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", bus.pending_rd_o); end
        if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err_o); end
    endtask

    task automatic test_alu();
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        for (int i = 0; i < 24; i++) begin
            v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rd = (i == 0) ? 5'd5 : ((i == 1) ? 5'd0 : 5'($urandom_range(0, 31)));
            d  = (i == 0) ? 32'h1234_5678 : $urandom;
            if (i == 1) v = 1'b1;
            bus.alu_valid_i = v;
            bus.alu_rd_i    = rd;
            bus.alu_data_i  = d;
            step();
            total++;
            if (v && rd != 0) begin
                if (bus.reg_we_o !== REG_WE || bus.rd_addr_o !== rd || bus.rd_data_o !== d) begin
                    bad++;
                    $display("FAIL alu_write[%0d] got we=%0d rd=%0d data=%h want we=1 rd=%0d data=%h", i, bus.reg_we_o, bus.rd_addr_o, bus.rd_data_o, rd, d);
                end
            end else if (bus.reg_we_o !== REG_NO_WE) begin
                bad++;
                $display("FAIL alu_nowrite[%0d] got we=%0d want 0 (v=%b rd=%0d)", i, bus.reg_we_o, v, rd);
            end
        end
        idle_inputs();
        step();
        total++;
        if (bus.reg_we_o !== REG_NO_WE || bus.stall_o !== 1'b0 || bus.err_o !== 1'b0) begin
            bad++;
            $display("FAIL alu_quiet got we=%0d stall=%b err=%b want 0/0/0", bus.reg_we_o, bus.stall_o, bus.err_o);
        end
    endtask

    task automatic test_loads();
        int          f3, off, lat;
        logic [4:0]  rd;
        logic [31:0] w, exp;
        for (int i = 0; i < 40; i++) begin
            case (i)
                0:       begin rd = 5'd3;  f3 = 0; off = 1; w = 32'h0000_8000; lat = 2; end
                1:       begin rd = 5'd10; f3 = 5; off = 2; w = 32'hBEEF_0000; lat = 1; end
                2:       begin rd = 5'd11; f3 = 1; off = 3; w = 32'h0;         lat = 0; end
                3:       begin rd = 5'd0;  f3 = 2; off = 0; w = $urandom;      lat = 3; end
                default: begin
                    rd  = 5'($urandom_range(0, 31));
                    f3  = $urandom_range(0, 7);
                    off = $urandom_range(0, 3);
                    w   = $urandom;
                    lat = $urandom_range(0, TMO - 1);
                end
            endcase
            bus.ld_issue_i  = 1'b1;
            bus.ld_rd_i     = rd;
            bus.ld_funct3_i = 3'(f3);
            bus.ld_offset_i = 2'(off);
            step();
            bus.ld_issue_i  = 1'b0;
            total++;
            if (!m_legal(f3, off)) begin
                if (bus.err_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.reg_we_o !== REG_NO_WE) begin
                    bad++;
                    $display("FAIL ld_illegal[%0d] f3=%0d off=%0d got err=%b stall=%b we=%0d want 1/0/0", i, f3, off, bus.err_o, bus.stall_o, bus.reg_we_o);
                end
                step();
                total++;
                if (bus.err_o !== 1'b0 || bus.stall_o !== 1'b0) begin
                    bad++;
                    $display("FAIL ld_illegal_after[%0d] got err=%b stall=%b want 0/0", i, bus.err_o, bus.stall_o);
                end
                continue;
            end
            if (bus.stall_o !== 1'b1 || bus.pending_rd_o !== rd || bus.err_o !== 1'b0) begin
                bad++;
                $display("FAIL ld_issue[%0d] got stall=%b pend=%0d err=%b want 1/%0d/0", i, bus.stall_o, bus.pending_rd_o, bus.err_o, rd);
            end
            for (int j = 0; j < lat; j++) begin
                // Traffic during the wait must be ignored.
                bus.alu_valid_i = 1'($urandom_range(0, 1));
                bus.alu_rd_i    = 5'($urandom_range(1, 31));
                bus.alu_data_i  = $urandom;
                bus.ld_issue_i  = 1'($urandom_range(0, 1));
                bus.ld_funct3_i = 3'($urandom_range(0, 7));
                bus.ld_offset_i = 2'($urandom_range(0, 3));
                bus.mem_rdata_i = $urandom;
                step();
                total++;
                if (bus.stall_o !== 1'b1 || bus.pending_rd_o !== rd || bus.reg_we_o !== REG_NO_WE || bus.err_o !== 1'b0) begin
                    bad++;
                    $display("FAIL ld_wait[%0d.%0d] got stall=%b pend=%0d we=%0d err=%b want 1/%0d/0/0", i, j, bus.stall_o, bus.pending_rd_o, bus.reg_we_o, bus.err_o, rd);
                end
            end
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = w;
            step();
            idle_inputs();
            exp = m_ext(f3, off, w);
            total++;
            if (rd != 0) begin
                if (bus.reg_we_o !== REG_WE || bus.rd_addr_o !== rd || bus.rd_data_o !== exp || bus.stall_o !== 1'b0 || bus.pending_rd_o !== 5'd0) begin
                    bad++;
                    $display("FAIL ld_write[%0d] f3=%0d off=%0d got we=%0d rd=%0d data=%h stall=%b pend=%0d want 1/%0d/%h/0/0", i, f3, off, bus.reg_we_o, bus.rd_addr_o, bus.rd_data_o, bus.stall_o, bus.pending_rd_o, rd, exp);
                end
            end else if (bus.reg_we_o !== REG_NO_WE || bus.stall_o !== 1'b0) begin
                bad++;
                $display("FAIL ld_x0[%0d] got we=%0d stall=%b want 0/0", i, bus.reg_we_o, bus.stall_o);
            end
        end
        step();
    endtask

    task automatic test_x0_simul();
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd0;
        bus.alu_data_i  = 32'hDEAD_BEEF;
        step();
        total++;
        if (bus.reg_we_o !== REG_NO_WE) begin bad++; $display("FAIL x0_alu got we=%0d want 0", bus.reg_we_o); end
        bus.alu_rd_i    = 5'd7;
        bus.alu_data_i  = 32'h0000_0777;
        bus.ld_issue_i  = 1'b1;
        bus.ld_rd_i     = 5'd8;
        bus.ld_funct3_i = LW;
        bus.ld_offset_i = 2'd0;
        step();
        idle_inputs();
        total++;
        if (bus.reg_we_o !== REG_WE || bus.rd_addr_o !== 5'd7 || bus.rd_data_o !== 32'h777 || bus.stall_o !== 1'b1 || bus.pending_rd_o !== 5'd8) begin
            bad++;
            $display("FAIL simul_issue got we=%0d rd=%0d data=%h stall=%b pend=%0d want 1/7/777/1/8", bus.reg_we_o, bus.rd_addr_o, bus.rd_data_o, bus.stall_o, bus.pending_rd_o);
        end
        step();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hCAFE_F00D;
        step();
        idle_inputs();
        total++;
        if (bus.reg_we_o !== REG_WE || bus.rd_addr_o !== 5'd8 || bus.rd_data_o !== 32'hCAFE_F00D || bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL simul_lw got we=%0d rd=%0d data=%h stall=%b want 1/8/cafef00d/0", bus.reg_we_o, bus.rd_addr_o, bus.rd_data_o, bus.stall_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2;
        w1 = $urandom;
        w2 = $urandom;
        bus.ld_issue_i  = 1'b1;
        bus.ld_rd_i     = 5'd12;
        bus.ld_funct3_i = LBU;
        bus.ld_offset_i = 2'd3;
        step();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = w1;
        step();
        idle_inputs();
        total++;
        if (bus.reg_we_o !== REG_WE || bus.rd_addr_o !== 5'd12 || bus.rd_data_o !== m_ext(4, 3, w1)) begin
            bad++;
            $display("FAIL b2b_first got we=%0d rd=%0d data=%h want 1/12/%h", bus.reg_we_o, bus.rd_addr_o, bus.rd_data_o, m_ext(4, 3, w1));
        end
        bus.ld_issue_i  = 1'b1;
        bus.ld_rd_i     = 5'd13;
        bus.ld_funct3_i = LH;
        bus.ld_offset_i = 2'd2;
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd14;
        bus.alu_data_i  = 32'h1414_1414;
        step();
        idle_inputs();
        total++;
        if (bus.stall_o !== 1'b1 || bus.pending_rd_o !== 5'd13 || bus.reg_we_o !== REG_WE || bus.rd_addr_o !== 5'd14) begin
            bad++;
            $display("FAIL b2b_second_issue got stall=%b pend=%0d we=%0d rd=%0d want 1/13/1/14", bus.stall_o, bus.pending_rd_o, bus.reg_we_o, bus.rd_addr_o);
        end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = w2;
        step();
        idle_inputs();
        total++;
        if (bus.reg_we_o !== REG_WE || bus.rd_addr_o !== 5'd13 || bus.rd_data_o !== m_ext(1, 2, w2)) begin
            bad++;
            $display("FAIL b2b_second got we=%0d rd=%0d data=%h want 1/13/%h", bus.reg_we_o, bus.rd_addr_o, bus.rd_data_o, m_ext(1, 2, w2));
        end
        step();
    endtask

    task automatic test_timeout();
        bus.ld_issue_i  = 1'b1;
        bus.ld_rd_i     = 5'd9;
        bus.ld_funct3_i = LW;
        bus.ld_offset_i = 2'd0;
        step();
        idle_inputs();
`ifdef WB_TIMEOUT_EN
        for (int k = 0; k < TMO - 1; k++) begin
            total++;
            if (bus.stall_o !== 1'b1 || bus.err_o !== 1'b0) begin
                bad++;
                $display("FAIL tmo_wait[%0d] got stall=%b err=%b want 1/0", k, bus.stall_o, bus.err_o);
            end
            step();
        end
        total++;
        if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL tmo_last got stall=%b want 1", bus.stall_o); end
        step();
        total++;
        if (bus.err_o !== 1'b1 || bus.stall_o !== 1'b0 || bus.reg_we_o !== REG_NO_WE || bus.pending_rd_o !== 5'd0) begin
            bad++;
            $display("FAIL tmo_abort got err=%b stall=%b we=%0d pend=%0d want 1/0/0/0", bus.err_o, bus.stall_o, bus.reg_we_o, bus.pending_rd_o);
        end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h5555_AAAA;
        step();
        idle_inputs();
        total++;
        if (bus.err_o !== 1'b0 || bus.reg_we_o !== REG_NO_WE) begin
            bad++;
            $display("FAIL tmo_late_rvalid got err=%b we=%0d want 0/0", bus.err_o, bus.reg_we_o);
        end
`else
        for (int k = 0; k < 30; k++) begin
            total++;
            if (bus.stall_o !== 1'b1 || bus.pending_rd_o !== 5'd9 || bus.err_o !== 1'b0) begin
                bad++;
                $display("FAIL hold_wait[%0d] got stall=%b pend=%0d err=%b want 1/9/0", k, bus.stall_o, bus.pending_rd_o, bus.err_o);
            end
            step();
        end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h5555_AAAA;
        step();
        idle_inputs();
        total++;
        if (bus.reg_we_o !== REG_WE || bus.rd_addr_o !== 5'd9 || bus.rd_data_o !== 32'h5555_AAAA || bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL hold_write got we=%0d rd=%0d data=%h stall=%b want 1/9/5555aaaa/0", bus.reg_we_o, bus.rd_addr_o, bus.rd_data_o, bus.stall_o);
        end
`endif
        step();
    endtask

    task automatic test_reset_midload();
        bus.ld_issue_i  = 1'b1;
        bus.ld_rd_i     = 5'd4;
        bus.ld_funct3_i = LH;
        bus.ld_offset_i = 2'd0;
        step();
        idle_inputs();
        total++;
        if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL midrst_pre got stall=%b want 1", bus.stall_o); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_1234;
        step();
        idle_inputs();
        total++;
        if (bus.reg_we_o !== REG_NO_WE || bus.stall_o !== 1'b0 || bus.pending_rd_o !== 5'd0 || bus.err_o !== 1'b0 || bus.rd_addr_o !== 5'd0 || bus.rd_data_o !== 32'd0) begin
            bad++;
            $display("FAIL midrst_post got we=%0d stall=%b pend=%0d err=%b rd=%0d data=%h want all 0", bus.reg_we_o, bus.stall_o, bus.pending_rd_o, bus.err_o, bus.rd_addr_o, bus.rd_data_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_alu();
        test_loads();
        test_x0_simul();
        test_back_to_back();
        test_timeout();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
